// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg: shared types and constants for the AXI read-address arbiter.
//   arb_state_e  : IDLE / ADDR / DATA arbitration phases
//   grant_t      : one-hot grant / request vector, bit i = master i
//   PTR_RESET    : last-winner value after reset (m2), giving m0 top priority
//   onehot_idx() : index of the set bit in a one-hot grant_t
package axi_arb_pkg;
  localparam int NUM_RMASTERS = 3;
  typedef enum logic [1:0] {IDLE, ADDR, DATA} arb_state_e;
  typedef logic [NUM_RMASTERS-1:0] grant_t;
  localparam grant_t PTR_RESET = 3'b100;
  function automatic logic [1:0] onehot_idx(grant_t g);
    return g[2] ? 2'd2 : g[1] ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/axi_read_arbiter_if.sv
// axi_read_arbiter_if: bundle of request, AR/R handshake and grant signals.
//   mN_ARVALID        : read-address request of master N
//   arvalid / arready : muxed AR handshake on the slave side
//   rvalid/rready/rlast : muxed R handshake and last-beat flag
//   mN_rgrnt / busy   : arbiter outputs (grants drive the AR mux select)
//   modport slave     : the arbiter's view; modport master : the environment's view
interface axi_read_arbiter_if;
  logic m0_ARVALID, m1_ARVALID, m2_ARVALID;
  logic arvalid, arready;
  logic rvalid, rready, rlast;
  logic m0_rgrnt, m1_rgrnt, m2_rgrnt;
  logic busy;
  modport slave (
    input  m0_ARVALID, m1_ARVALID, m2_ARVALID, arvalid, arready, rvalid, rready, rlast,
    output m0_rgrnt, m1_rgrnt, m2_rgrnt, busy
  );
  modport master (
    output m0_ARVALID, m1_ARVALID, m2_ARVALID, arvalid, arready, rvalid, rready, rlast,
    input  m0_rgrnt, m1_rgrnt, m2_rgrnt, busy
  );
endinterface

// File: rtl/arb_rr_pick.sv
// arb_rr_pick: combinational winner select.
//   req_i  : request vector, bit i = master i
//   last_i : one-hot last winner; search starts at the master after it, wrapping
//   win_o  : one-hot winner, all-zero when no request
module arb_rr_pick
  import axi_arb_pkg::*;
(
  input  grant_t req_i,
  input  grant_t last_i,
  output grant_t win_o
);
  logic [1:0] li, idx;
  // Walk from the farthest candidate to the nearest so the nearest requester overwrites.
  always_comb begin
    win_o = '0;
    idx   = '0;
    li    = onehot_idx(last_i);
    for (int k = NUM_RMASTERS; k >= 1; k--) begin
      idx = 2'((int'(li) + k) % NUM_RMASTERS);
      if (req_i[idx]) begin
        win_o      = '0;
        win_o[idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: 3-master AXI read-address arbiter with registered one-hot grants.
//   clk   : single clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : axi_read_arbiter_if.slave (requests, AR/R handshakes in; grants, busy out)
//   HOLD_RDATA : 1 holds the grant until the last R beat, 0 releases after AR handshake
//   AXI_ARB_RR_EN : when defined, round-robin from the last winner; otherwise m0 > m1 > m2
module axi_read_arbiter
  import axi_arb_pkg::*;
#(
  parameter bit HOLD_RDATA = 1'b1
) (
  input logic clk,
  input logic rst_n,
  axi_read_arbiter_if.slave bus
);
  arb_state_e state_q;
  grant_t     grant_q, req, win, last_w;
  logic       busy_q, ar_hs, r_done, own_req;
  assign req     = {bus.m2_ARVALID, bus.m1_ARVALID, bus.m0_ARVALID};
  assign ar_hs   = bus.arvalid && bus.arready;
  assign r_done  = bus.rvalid && bus.rready && bus.rlast;
  assign own_req = |(req & grant_q);
`ifdef AXI_ARB_RR_EN
  grant_t ptr_q;
  assign last_w = ptr_q;
`else
  // Fixed priority is round-robin frozen at last-winner = m2.
  assign last_w = PTR_RESET;
`endif
  arb_rr_pick u_pick (
    .req_i  (req),
    .last_i (last_w),
    .win_o  (win)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      busy_q  <= 1'b0;
`ifdef AXI_ARB_RR_EN
      ptr_q   <= PTR_RESET;
`endif
    end else begin
      case (state_q)
        IDLE: if (|req) begin
          grant_q <= win;
          state_q <= ADDR;
          busy_q  <= 1'b1;
        end
        ADDR: if (ar_hs) begin
`ifdef AXI_ARB_RR_EN
          ptr_q <= grant_q;
`endif
          if (HOLD_RDATA) state_q <= DATA;
          else begin
            state_q <= IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
          end
        end else if (!own_req) begin
          // Granted master withdrew its request: abort without moving the pointer.
          state_q <= IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
        DATA: if (r_done) begin
          state_q <= IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
  assign bus.m0_rgrnt = grant_q[0];
  assign bus.m1_rgrnt = grant_q[1];
  assign bus.m2_rgrnt = grant_q[2];
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: randomized check of both HOLD_RDATA variants against a transaction-level model.
module tb_axi_read_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] req = '0;
  logic arr = 1'b0, rv = 1'b0, rr = 1'b0, rl = 1'b0;
  int vectors = 0, errors = 0;
  int owner [2];
  bit in_data [2];
  int last [2];

  axi_read_arbiter_if bh ();
  axi_read_arbiter_if bn ();

  axi_read_arbiter #(.HOLD_RDATA(1'b1)) dut_h (.clk(clk), .rst_n(rst_n), .bus(bh));
  axi_read_arbiter #(.HOLD_RDATA(1'b0)) dut_n (.clk(clk), .rst_n(rst_n), .bus(bn));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic int pick(logic [2:0] r, int l);
`ifdef AXI_ARB_RR_EN
    for (int k = 1; k <= 3; k++) if (r[(l + k) % 3]) return (l + k) % 3;
`else
    for (int i = 0; i < 3; i++) if (r[i]) return i;
`endif
    return -1;
  endfunction

  function automatic logic [2:0] exp_grant(int o);
    logic [2:0] g;
    g = '0;
    if (o >= 0) g[o] = 1'b1;
    return g;
  endfunction

  task automatic apply();
    logic av [2];
    for (int d = 0; d < 2; d++) av[d] = (owner[d] >= 0) ? req[owner[d]] : 1'b0;
    {bh.m2_ARVALID, bh.m1_ARVALID, bh.m0_ARVALID} = req;
    {bn.m2_ARVALID, bn.m1_ARVALID, bn.m0_ARVALID} = req;
    bh.arvalid = av[0]; bn.arvalid = av[1];
    bh.arready = arr;   bn.arready = arr;
    bh.rvalid = rv;     bn.rvalid = rv;
    bh.rready = rr;     bn.rready = rr;
    bh.rlast = rl;      bn.rlast = rl;
  endtask

  task automatic step();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        owner[d] = -1; in_data[d] = 0; last[d] = 2;
      end else if (owner[d] < 0) begin
        owner[d] = pick(req, last[d]); in_data[d] = 0;
      end else if (!in_data[d]) begin
        if (req[owner[d]] && arr) begin
          last[d] = owner[d];
          if (d == 0) in_data[d] = 1; else owner[d] = -1;
        end else if (!req[owner[d]]) owner[d] = -1;
      end else if (rv && rr && rl) begin
        owner[d] = -1; in_data[d] = 0;
      end
    end
    #1;
    check("hold_grant", {1'b0, bh.m2_rgrnt, bh.m1_rgrnt, bh.m0_rgrnt}, {1'b0, exp_grant(owner[0])});
    check("hold_busy",  {3'b0, bh.busy}, {3'b0, owner[0] >= 0});
    check("nohold_grant", {1'b0, bn.m2_rgrnt, bn.m1_rgrnt, bn.m0_rgrnt}, {1'b0, exp_grant(owner[1])});
    check("nohold_busy",  {3'b0, bn.busy}, {3'b0, owner[1] >= 0});
    apply();
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin owner[d] = -1; in_data[d] = 0; last[d] = 2; end
    req = 3'b111;
    apply();
    repeat (2) step();
    rst_n = 1'b1;
    arr = 1'b1; rv = 1'b1; rr = 1'b1; rl = 1'b1;
    apply();
    repeat (16) step();
    req = 3'b001; arr = 1'b0;
    apply();
    step();
    req = 3'b000;
    apply();
    repeat (2) step();
    req = 3'b111; arr = 1'b1; rl = 1'b0;
    apply();
    repeat (4) step();
    rst_n = 1'b0;
    apply();
    step();
    rst_n = 1'b1; rl = 1'b1;
    apply();
    repeat (6) step();
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 3) == 0) req = 3'($urandom);
      arr = 1'($urandom);
      rv = 1'($urandom);
      rr = ($urandom_range(0, 3) != 0);
      rl = ($urandom_range(0, 2) == 0);
      apply();
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/axi_read_arbiter.md
AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Interface
REQ-001 SHALL have parameter HOLD_RDATA, default 1, meaning: grant held until the read burst's last beat (1) or released after the AR handshake (0).
REQ-002 SHALL use one clock; reset is synchronous and active-low.
REQ-003 clk  input  1  single clock, all state updates on its rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 m0_ARVALID, m1_ARVALID, m2_ARVALID  input  1 each  read-address requests from masters 0..2.
REQ-006 arvalid  input  1  muxed AR valid toward the slave side.
REQ-007 arready  input  1  slave AR ready.
REQ-008 rvalid, rready, rlast  input  1 each  muxed R-channel handshake and last-beat flag.
REQ-009 m0_rgrnt, m1_rgrnt, m2_rgrnt  output  1 each  registered grants driving the AR mux select.
REQ-010 busy  output  1  high whenever state is not IDLE.

Function
REQ-011 Grants SHALL be registered and at most one-hot; all-zero means no master selected.
REQ-012 States SHALL be IDLE, ADDR and DATA.
REQ-013 In IDLE with any ARVALID high, the winner is selected and its grant asserted the next cycle (1-cycle latency), entering ADDR.
REQ-014 In IDLE with no ARVALID high, grants stay zero and state stays IDLE.
REQ-015 In ADDR, the grant is held until arvalid && arready; that cycle the priority pointer updates to the winner.
REQ-016 After the AR handshake with HOLD_RDATA=1, the state goes to DATA with the grant held; with HOLD_RDATA=0, it goes to IDLE and the grant clears the next cycle.
REQ-017 In DATA, the grant is held until rvalid && rready && rlast, then the state goes to IDLE and the grant clears; R beats without rlast do not change state.
REQ-018 In ADDR, if the granted master's ARVALID is low, the grant clears, the state goes to IDLE and the pointer does not update (abort).
REQ-019 Returning to IDLE SHALL cost one bubble cycle with all grants zero before any new grant.
REQ-020 ARVALID changes from non-granted masters SHALL NOT affect the state in ADDR or DATA.
REQ-021 busy SHALL be 0 in IDLE and 1 in ADDR and DATA.

Reset
REQ-022 On rst_n low at a clock edge, including mid-burst: state becomes IDLE, all grants and busy become 0, and the pointer is set to last-winner = m2, so m0 has top priority.
REQ-023 The first arbitration SHALL occur in the cycle after rst_n deasserts.

Configuration
REQ-024 With macro AXI_ARB_RR_EN defined, selection SHALL be round-robin: the search starts at the master after the last winner, wrapping from m2 to m0.
REQ-025 Without AXI_ARB_RR_EN, selection SHALL be fixed priority m0 > m1 > m2; the pointer register is absent or ignored.

Structure
REQ-026 Shared package axi_arb_pkg SHALL hold the state enum (IDLE/ADDR/DATA), localparam NUM_RMASTERS = 3 and the grant-vector typedef.
REQ-027 One combinational sub-module, arb_rr_pick, SHALL take the request vector and the last-winner pointer and return the one-hot winner.

Verification
REQ-028 Single request: m1_ARVALID=1 at cycle 0, arready=1 at cycle 2, rlast beat at cycle 5 -> m1_rgrnt=1 in cycles 1..5, 0 at cycle 6, busy follows the grant.
REQ-029 Contention with RR: all three ARVALID held high, each burst 1 beat -> grant order m0, m1, m2, m0, with a single all-zero cycle between grants.
REQ-030 Fixed priority without the macro: all three ARVALID high, 3 bursts -> m0 granted every time while m0_ARVALID stays high.
REQ-031 HOLD_RDATA=0: m2 AR handshake at cycle 1 -> grant cleared at cycle 2, next request granted at cycle 3 while rlast for m2 is still outstanding.
REQ-032 Abort: m0 granted, m0_ARVALID dropped before arready -> grant 0 next cycle, busy 0, next contention starts from the unchanged pointer.
REQ-033 Reset mid-DATA: rst_n low during beat 2 of 4 -> grants and busy 0 the next cycle, state IDLE, m0 wins the next 3-way request.
